// File: rtl/dot_matrix_scroll_ctrl_pkg.sv
// Shared types, constants and helpers for the dot-matrix scroll controller.
// The font table here is the single source of glyph data for the ROM.
package dot_matrix_scroll_ctrl_pkg;

  typedef enum logic [1:0] {StAddrA, StAddrB, StLoad, StHold} scan_state_e;

  localparam logic [6:0] SpaceCode = 7'h20;
  localparam int unsigned CodeW = 7;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic scan_state_e scan_state(input int unsigned cnt);
    if (cnt == 0) return StAddrA;
    if (cnt == 1) return StAddrB;
    if (cnt == 2) return StLoad;
    return StHold;
  endfunction

  // 8x8 glyphs, row 0 in bits 63:56, MSB of each row is the leftmost pixel.
  function automatic logic [63:0] font_glyph(input logic [6:0] code);
    case (code)
      7'h30:   return 64'h3C666E7666663C00;
      7'h31:   return 64'h1838181818187E00;
      7'h32:   return 64'h3C66060C30607E00;
      7'h33:   return 64'h3C66061C06663C00;
      7'h41:   return 64'h183C66667E666600;
      7'h42:   return 64'h7C66667C66667C00;
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/dot_matrix_scroll_ctrl_if.sv
// Game-logic side buffer/mode controls and matrix pin outputs.
interface dot_matrix_scroll_ctrl_if
  import dot_matrix_scroll_ctrl_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned NUM_CHARS = 4
);
  // One spare code point so out-of-range indices are representable.
  localparam int unsigned AddrW = clog2_min1(NUM_CHARS + 1);

  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [6:0]       wr_data;
  logic             scroll_en;
  logic [AddrW-1:0] char_sel;
  logic             blank;
  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic             frame_start;

  modport master (
    output wr_en, wr_addr, wr_data, scroll_en, char_sel, blank,
    input  row, col, frame_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, scroll_en, char_sel, blank,
    output row, col, frame_start
  );

endinterface

// File: rtl/dot_matrix_scroll_ctrl_font_rom.sv
// Synchronous font ROM, one-cycle latency; address is {code, row_idx}.
module dot_matrix_scroll_ctrl_font_rom
  import dot_matrix_scroll_ctrl_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  localparam int unsigned RowW = clog2_min1(ROWS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CodeW+RowW-1:0]   addr_i,
  output logic [COLS-1:0]         data_o
);

  logic [63:0]     glyph;
  logic [7:0]      bits;
  logic [COLS+7:0] wide;
  logic [COLS-1:0] data_d, data_q;

  always_comb begin
    glyph  = font_glyph(addr_i[CodeW+RowW-1 -: CodeW]);
    glyph  = glyph << (32'(addr_i[RowW-1:0]) * 8);
    bits   = (32'(addr_i[RowW-1:0]) < 8) ? glyph[63:56] : 8'h00;
    // Crop or zero-pad the 8-wide glyph to COLS, keeping it left-aligned.
    wide   = {bits, COLS'(0)};
    data_d = wide[COLS+7 -: COLS];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/dot_matrix_scroll_ctrl.sv
// Row-scanning dot-matrix controller: character buffer, two-glyph fetch per row,
// barrel-extracted window for static or scrolling display.
module dot_matrix_scroll_ctrl
  import dot_matrix_scroll_ctrl_pkg::*;
#(
  parameter int unsigned ROWS          = 8,
  parameter int unsigned COLS          = 8,
  parameter int unsigned NUM_CHARS     = 4,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned SCROLL_FRAMES = 8
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  dot_matrix_scroll_ctrl_if.slave bus_io
);

  localparam int unsigned Strip  = NUM_CHARS * COLS;
  localparam int unsigned RowW   = clog2_min1(ROWS);
  localparam int unsigned DivW   = clog2_min1(SCAN_DIV);
  localparam int unsigned StripW = clog2_min1(Strip);
  localparam int unsigned FrmW   = clog2_min1(SCROLL_FRAMES);
  localparam int unsigned ChW    = clog2_min1(NUM_CHARS);

  logic [6:0]       chars_q [NUM_CHARS];
  logic [DivW-1:0]  div_q, div_d;
  logic [RowW-1:0]  row_idx_q, row_idx_d;
  logic [StripW-1:0] offset_q, offset_d;
  logic [FrmW-1:0]  frame_q, frame_d;
  logic [COLS-1:0]  a_row_q, a_row_d;
  logic [ROWS-1:0]  strobe_q, strobe_d;
  logic [COLS-1:0]  col_q, col_d;
  logic             fs_q, fs_d;

  scan_state_e          state;
  int unsigned          a_idx, b_idx, shift, sel;
  logic [6:0]           rom_code;
  logic [COLS-1:0]      rom_data;
  logic [2*COLS-1:0]    window;
  logic                 row_end, frame_end;

  dot_matrix_scroll_ctrl_font_rom #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_font_rom (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i ({rom_code, row_idx_q}),
    .data_o (rom_data)
  );

  always_comb begin
    state     = scan_state(32'(div_q));
    a_idx     = 32'(offset_q) / COLS;
    b_idx     = (a_idx + 1) % NUM_CHARS;
    shift     = 32'(offset_q) % COLS;
    rom_code  = (state == StAddrA) ? chars_q[ChW'(a_idx)] : chars_q[ChW'(b_idx)];
    window    = {a_row_q, rom_data} << shift;
    row_end   = (div_q == DivW'(SCAN_DIV - 1));
    frame_end = row_end && (row_idx_q == RowW'(ROWS - 1));

    div_d     = row_end ? '0 : div_q + DivW'(1);
    row_idx_d = row_idx_q;
    if (row_end) row_idx_d = (row_idx_q == RowW'(ROWS - 1)) ? '0 : row_idx_q + RowW'(1);

    // Offset only moves at frame end so a frame never shows two offsets.
    offset_d = offset_q;
    frame_d  = frame_q;
    sel      = 0;
    if (frame_end) begin
      if (bus_io.scroll_en) begin
        if (frame_q == FrmW'(SCROLL_FRAMES - 1)) begin
          frame_d  = '0;
          offset_d = (offset_q == StripW'(Strip - 1)) ? '0 : offset_q + StripW'(1);
        end else begin
          frame_d = frame_q + FrmW'(1);
        end
      end else begin
        if (32'(bus_io.char_sel) < NUM_CHARS) sel = 32'(bus_io.char_sel);
        offset_d = StripW'(sel * COLS);
        frame_d  = '0;
      end
    end

    a_row_d  = (state == StAddrB) ? rom_data : a_row_q;
    strobe_d = strobe_q;
    col_d    = col_q;
    fs_d     = 1'b0;
    if (state == StLoad) begin
      strobe_d = ROWS'(1) << row_idx_q;
      col_d    = bus_io.blank ? '0 : window[2*COLS-1 -: COLS];
      fs_d     = (row_idx_q == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      row_idx_q <= '0;
      offset_q  <= '0;
      frame_q   <= '0;
      a_row_q   <= '0;
      strobe_q  <= '0;
      col_q     <= '0;
      fs_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_CHARS); i++) chars_q[i] <= SpaceCode;
    end else begin
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      offset_q  <= offset_d;
      frame_q   <= frame_d;
      a_row_q   <= a_row_d;
      strobe_q  <= strobe_d;
      col_q     <= col_d;
      fs_q      <= fs_d;
      if (bus_io.wr_en && (32'(bus_io.wr_addr) < NUM_CHARS)) begin
        chars_q[ChW'(bus_io.wr_addr)] <= bus_io.wr_data;
      end
    end
  end

  assign bus_io.row         = strobe_q;
  assign bus_io.col         = col_q;
  assign bus_io.frame_start = fs_q;

endmodule

// File: tb/tb_dot_matrix_scroll_ctrl.sv
// Directed bench for dot_matrix_scroll_ctrl with SCAN_DIV=8, SCROLL_FRAMES=1.
module tb_dot_matrix_scroll_ctrl;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   tcyc;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dot_matrix_scroll_ctrl_if #(.ROWS(8), .COLS(8), .NUM_CHARS(4)) bus ();

  dot_matrix_scroll_ctrl #(
    .ROWS          (8),
    .COLS          (8),
    .NUM_CHARS     (4),
    .SCAN_DIV      (8),
    .SCROLL_FRAMES (1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  // Edges since reset release: div_cnt = tcyc%8, row_idx = (tcyc/8)%8.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) tcyc <= 0;
    else         tcyc <= tcyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle(input int c);
    while (tcyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [6:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  function automatic logic [7:0] glyph_row(input logic [6:0] code, input int r);
    logic [63:0] g;
    case (code)
      7'h41:   g = 64'h183C66667E666600;
      7'h42:   g = 64'h7C66667C66667C00;
      default: g = 64'h0;
    endcase
    g = g << (8 * r);
    return g[63:56];
  endfunction

  task automatic check_out(input string tag, input logic [7:0] r, input logic [7:0] c);
    check({tag, ".row"}, bus.row, r);
    check({tag, ".col"}, bus.col, c);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.scroll_en = 0; bus.char_sel = 0; bus.blank = 0;
    repeat (3) @(posedge clk);
    #1;
    check_out("in_reset", 8'h00, 8'h00);
    check("in_reset.fs", bus.frame_start, 0);
    rst_ni = 1'b1;

    // Reset release: nothing until the first LOAD is visible at cycle 3
    for (int c = 0; c < 3; c++) begin
      to_cycle(c);
      check_out($sformatf("rel_c%0d", c), 8'h00, 8'h00);
    end
    to_cycle(3);
    check_out("rel_c3", 8'h01, 8'h00);
    check("rel_c3.fs", bus.frame_start, 1);
    to_cycle(4);
    check("rel_c4.fs", bus.frame_start, 0);

    // Static 'A' from entry 2; offset takes effect from frame 1
    bus.char_sel = 3'd2;
    wr(3'd2, 7'h41);
    for (int r = 0; r < 8; r++) begin
      to_cycle(64 + 8 * r + 3);
      check_out($sformatf("static_r%0d", r), 8'(1 << r), glyph_row(7'h41, r));
      if (r == 0) check("static_fs", bus.frame_start, 1);
      to_cycle(64 + 8 * r + 7);
      check($sformatf("static_hold_r%0d", r), bus.col, glyph_row(7'h41, r));
    end
    to_cycle(128 + 3);
    check_out("static_repeat", 8'h01, 8'h18);

    // Blank across row 3 LOAD of frame 2
    to_cycle(153);
    bus.blank = 1'b1;
    to_cycle(155);
    check_out("blank_r3", 8'h08, 8'h00);
    to_cycle(156);
    bus.blank = 1'b0;
    to_cycle(163);
    check_out("unblank_r4", 8'h10, 8'h7E);

    // Out-of-range writes must not alias onto real entries
    to_cycle(170);
    wr(3'd5, 7'h42);
    wr(3'd6, 7'h42);
    wr(3'd7, 7'h42);
    to_cycle(195);
    check_out("oob_r0", 8'h01, 8'h18);
    to_cycle(203);
    check_out("oob_r1", 8'h02, 8'h3C);

    // Collision: write entry 2 during row 3 ADDR_A
    to_cycle(216);
    wr(3'd2, 7'h42);
    to_cycle(219);
    check_out("coll_old_r3", 8'h08, 8'h66);
    to_cycle(227);
    check_out("coll_new_r4", 8'h10, 8'h66);
    to_cycle(235);
    check_out("coll_new_r5", 8'h20, 8'h66);

    // Scroll: "0123", static offset 0 at frame 5, then +1 per frame
    to_cycle(256);
    bus.char_sel = 3'd0;
    wr(3'd0, 7'h30);
    wr(3'd1, 7'h31);
    wr(3'd2, 7'h32);
    wr(3'd3, 7'h33);
    to_cycle(320);
    bus.scroll_en = 1'b1;
    to_cycle(323);  check_out("scr_o0_r0", 8'h01, 8'h3C);
    to_cycle(387);  check_out("scr_o1_r0", 8'h01, 8'h78);
    to_cycle(395);  check_out("scr_o1_r1", 8'h02, 8'hCC);
    to_cycle(1091); check_out("scr_o12_r0", 8'h01, 8'h83);
    to_cycle(1139); check_out("scr_o12_r6", 8'h40, 8'hE7);
    to_cycle(2115); check_out("scr_o28_r0", 8'h01, 8'hC3);
    to_cycle(2139); check_out("scr_o28_r3", 8'h08, 8'hC7);
    to_cycle(2307); check_out("scr_o31_r0", 8'h01, 8'h1E);
    to_cycle(2323); check_out("scr_o31_r2", 8'h04, 8'h37);
    to_cycle(2371); check_out("scr_wrap_r0", 8'h01, 8'h3C);
    to_cycle(2387); check_out("scr_wrap_r2", 8'h04, 8'h6E);

    // Mid-frame reset at row 5
    to_cycle(2476);
    check("pre_rst.row", bus.row, 8'h20);
    #2;
    rst_ni = 1'b0;
    #1;
    check_out("mid_rst", 8'h00, 8'h00);
    check("mid_rst.fs", bus.frame_start, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    to_cycle(3);
    check_out("post_rst_r0", 8'h01, 8'h00);
    check("post_rst.fs", bus.frame_start, 1);
    wr(3'd0, 7'h30);
    wr(3'd1, 7'h31);
    wr(3'd2, 7'h32);
    wr(3'd3, 7'h33);
    to_cycle(11);
    check_out("post_rst_r1", 8'h02, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
